// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: synchronizes and qualifies pll_locked, then sequences downstream reset release.
// Optional PLL re-kick on lock timeout is enabled with `define LOCK_TIMEOUT_EN.
module pll_lock_supervisor #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned HOLD_CYCLES    = 16,
    parameter int unsigned LOSS_CNT_W     = 8,
    parameter int unsigned TIMEOUT_CYCLES = 65536,
    parameter int unsigned PLL_RST_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    output logic                  sys_rst_n,
    output logic                  ready,
    output logic                  lock_lost,
    output logic [LOSS_CNT_W-1:0] loss_count,
    output logic                  pll_rst
);

    localparam int unsigned HOLD_CW = $clog2(HOLD_CYCLES) + 1;
    localparam int unsigned STAB_CW = $clog2(STABLE_CYCLES) + 1;
    localparam logic [HOLD_CW-1:0] HOLD_LAST = HOLD_CW'(HOLD_CYCLES - 1);
    localparam logic [STAB_CW-1:0] STAB_LAST = STAB_CW'(STABLE_CYCLES - 1);

    typedef enum logic [2:0] {
        HOLD,
        WAIT_LOCK,
        STABILIZE,
        RUN,
        LOST,
        PLL_RESET
    } state_e;

    state_e                  state_q;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic [HOLD_CW-1:0]      hold_cnt_q;
    logic [STAB_CW-1:0]      stable_cnt_q;
    logic                    sys_rst_n_q;
    logic                    ready_q;
    logic                    lock_lost_q;
    logic [LOSS_CNT_W-1:0]   loss_cnt_q;
    logic [LOSS_CNT_W-1:0]   loss_cnt_d;
    logic                    lk;

    // The chain is flushed while in HOLD so qualification always starts from a fresh
    // synchronizer; this makes the sync latency additive to the hold time.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else if (state_q == HOLD) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign lk         = sync_q[SYNC_STAGES-1];
    assign loss_cnt_d = (&loss_cnt_q) ? loss_cnt_q : loss_cnt_q + LOSS_CNT_W'(1);

`ifdef LOCK_TIMEOUT_EN
    localparam int unsigned TMO_CW  = $clog2(TIMEOUT_CYCLES) + 1;
    localparam int unsigned PRST_CW = $clog2(PLL_RST_CYCLES) + 1;
    localparam logic [TMO_CW-1:0]  TMO_LAST  = TMO_CW'(TIMEOUT_CYCLES - 1);
    localparam logic [PRST_CW-1:0] PRST_LAST = PRST_CW'(PLL_RST_CYCLES - 1);

    logic [TMO_CW-1:0]  tmo_cnt_q;
    logic [PRST_CW-1:0] prst_cnt_q;
    logic               pll_rst_q;
    logic               tmo_hit;

    assign tmo_hit = (tmo_cnt_q == TMO_LAST);

    // Counts only across WAIT_LOCK/STABILIZE; any other state leaves it cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= '0;
        end else if ((state_q == WAIT_LOCK || state_q == STABILIZE) && !tmo_hit) begin
            tmo_cnt_q <= tmo_cnt_q + TMO_CW'(1);
        end else begin
            tmo_cnt_q <= '0;
        end
    end

    assign pll_rst = pll_rst_q;
`else
    assign pll_rst = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            stable_cnt_q <= '0;
            sys_rst_n_q  <= 1'b0;
            ready_q      <= 1'b0;
            lock_lost_q  <= 1'b0;
            loss_cnt_q   <= '0;
`ifdef LOCK_TIMEOUT_EN
            prst_cnt_q   <= '0;
            pll_rst_q    <= 1'b0;
`endif
        end else begin
            lock_lost_q <= 1'b0;
            case (state_q)
                HOLD: begin
                    if (hold_cnt_q == HOLD_LAST) begin
                        state_q    <= WAIT_LOCK;
                        hold_cnt_q <= '0;
                    end else begin
                        hold_cnt_q <= hold_cnt_q + HOLD_CW'(1);
                    end
                end
                WAIT_LOCK: begin
`ifdef LOCK_TIMEOUT_EN
                    if (tmo_hit) begin
                        state_q    <= PLL_RESET;
                        pll_rst_q  <= 1'b1;
                        prst_cnt_q <= '0;
                    end else
`endif
                    if (lk) begin
                        state_q      <= STABILIZE;
                        stable_cnt_q <= '0;
                    end
                end
                STABILIZE: begin
`ifdef LOCK_TIMEOUT_EN
                    if (tmo_hit) begin
                        state_q      <= PLL_RESET;
                        pll_rst_q    <= 1'b1;
                        prst_cnt_q   <= '0;
                        stable_cnt_q <= '0;
                    end else
`endif
                    if (!lk) begin
                        state_q      <= WAIT_LOCK;
                        stable_cnt_q <= '0;
                    end else if (stable_cnt_q == STAB_LAST) begin
                        state_q      <= RUN;
                        stable_cnt_q <= '0;
                        sys_rst_n_q  <= 1'b1;
                        ready_q      <= 1'b1;
                    end else begin
                        stable_cnt_q <= stable_cnt_q + STAB_CW'(1);
                    end
                end
                RUN: begin
                    if (!lk) begin
                        state_q     <= LOST;
                        sys_rst_n_q <= 1'b0;
                        ready_q     <= 1'b0;
                        lock_lost_q <= 1'b1;
                        loss_cnt_q  <= loss_cnt_d;
                    end
                end
                LOST: begin
                    state_q    <= HOLD;
                    hold_cnt_q <= '0;
                end
`ifdef LOCK_TIMEOUT_EN
                PLL_RESET: begin
                    if (prst_cnt_q == PRST_LAST) begin
                        state_q    <= HOLD;
                        hold_cnt_q <= '0;
                        pll_rst_q  <= 1'b0;
                    end else begin
                        prst_cnt_q <= prst_cnt_q + PRST_CW'(1);
                    end
                end
`endif
                default: state_q <= HOLD;
            endcase
        end
    end

    assign sys_rst_n  = sys_rst_n_q;
    assign ready      = ready_q;
    assign lock_lost  = lock_lost_q;
    assign loss_count = loss_cnt_q;

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
- Sits in the free-running 25 MHz oscillator domain, on the consumer side of the HDMI PLL's `locked` output.
- Synchronizes and qualifies `locked`, then sequences a clean reset release for downstream clock domains (TMDS serializer, video timing).
- Detects and counts loss-of-lock events and, optionally, re-kicks the PLL if lock is never achieved.

Parameters:
- SYNC_STAGES, 2, flops in the `locked` synchronizer chain (legal 2..4).
- STABLE_CYCLES, 1024, consecutive qualified-high cycles required before release (≥1).
- HOLD_CYCLES, 16, minimum cycles `sys_rst_n` stays low after any drop (≥1).
- LOSS_CNT_W, 8, width of the loss-of-lock event counter.
- TIMEOUT_CYCLES, 65536, cycles in WAIT_LOCK before a PLL reset pulse (LOCK_TIMEOUT_EN only).
- PLL_RST_CYCLES, 8, width in cycles of the PLL reset pulse (LOCK_TIMEOUT_EN only).

Ports:
- clk  in  1  free-running 25 MHz reference clock (not a PLL output)
- rst_n  in  1  asynchronous active-low reset
- pll_locked  in  1  PLL lock indicator, asynchronous to clk
- sys_rst_n  out  1  downstream reset; async assert, sync deassert
- ready  out  1  high while in RUN
- lock_lost  out  1  one-cycle pulse on each RUN→LOST transition
- loss_count  out  LOSS_CNT_W  saturating count of lock-loss events
- pll_rst  out  1  PLL reset request, active high

Behaviour:
- Reset values while rst_n low:
  - sys_rst_n=0, ready=0, lock_lost=0, loss_count=0, pll_rst=0.
  - State = HOLD, all counters 0, synchronizer flops 0.
- Synchronization:
  - pll_locked passes through SYNC_STAGES flops; `lk` is the last stage.
  - No other logic samples pll_locked directly.
- States:
  - HOLD: sys_rst_n=0. Counts HOLD_CYCLES cycles, then → WAIT_LOCK. `lk` is ignored in HOLD.
  - WAIT_LOCK: sys_rst_n=0.
    - lk=1 → STABILIZE with stable counter cleared.
  - STABILIZE: sys_rst_n=0.
    - Stable counter increments each cycle lk=1.
    - lk=0 → WAIT_LOCK (counter cleared; not counted as a loss).
    - Counter reaching STABLE_CYCLES-1 while lk=1 → RUN.
  - RUN: sys_rst_n=1, ready=1.
    - lk=0 → LOST; lock_lost pulses in the same cycle the state register becomes LOST.
  - LOST: sys_rst_n=0 and ready=0 immediately (registered, i.e. the cycle after lk fell).
    - loss_count increments once and saturates at all-ones.
    - Next cycle → HOLD.
- Latency:
  - pll_locked rising to sys_rst_n high = SYNC_STAGES + HOLD/WAIT residue + STABLE_CYCLES + 1 cycles.
  - From power-up with pll_locked already high: exactly SYNC_STAGES + HOLD_CYCLES + STABLE_CYCLES + 1 cycles after rst_n deasserts.
- sys_rst_n, ready and lock_lost are registered outputs; no combinational path from pll_locked.
- Glitch rule: an lk low pulse of even one cycle in STABILIZE restarts qualification; in RUN it causes a full LOST→HOLD sequence.
- Counter widths:
  - Derived with $clog2 of the relevant parameter + 1.
  - No counter wraps; each is cleared on state entry.
- rst_n asserted mid-operation: all outputs return to reset values asynchronously, including loss_count.

Optional Feature:
- Macro LOCK_TIMEOUT_EN.
- Defined:
  - A timeout counter runs while in WAIT_LOCK or STABILIZE (cleared on entry to WAIT_LOCK from HOLD, on entry to RUN, and on pll_rst completion).
  - On reaching TIMEOUT_CYCLES-1 the block drives pll_rst=1 for PLL_RST_CYCLES cycles, then returns to HOLD.
  - pll_rst is registered, reset to 0, and never asserted in RUN.
  - A timeout does not increment loss_count.
- Undefined: pll_rst tied to 0, no timeout counter; the block waits in WAIT_LOCK indefinitely.

Test Plan:
- Power-up, pll_locked=1 constant, defaults: sys_rst_n and ready rise together exactly 2+16+1024+1=1043 cycles after rst_n deasserts. lock_lost never pulses; loss_count=0.
- Lock glitch in STABILIZE: pll_locked low for 1 cycle at stable count 500 → no release at cycle 1043; release occurs 1024+ cycles after lk recovers; loss_count stays 0.
- Loss in RUN: drop pll_locked for 3 cycles → sys_rst_n=0 and lock_lost=1 for exactly one cycle at SYNC_STAGES+1 after the drop; loss_count=1; re-release after HOLD_CYCLES+STABLE_CYCLES.
- Saturation: LOSS_CNT_W=2, five loss events → loss_count sequence 1,2,3,3,3.
- Async reset mid-STABILIZE: rst_n low at any edge → all outputs 0 without waiting for a clk edge; after release the full qualification restarts.
- LOCK_TIMEOUT_EN with TIMEOUT_CYCLES=100 and pll_locked=0 → pll_rst high for 8 cycles starting 16+100 cycles after rst_n release, repeating every 16+100+8 cycles. sys_rst_n stays 0; loss_count stays 0.
